// File: rtl/xvc_jtag_shifter.sv
`timescale 1ns/1ps
// Purpose : serialises XVC shift commands (header N, then TMS/TDI word pairs) onto JTAG TCK/TMS/TDI
//           and returns the captured TDO, one 32-bit AXI-Stream word per word pair (tlast on the final one).
// Latency : 2*TCK_DIV clk cycles per JTAG bit; TDO word valid the cycle after the word's last TCK fall.
// Backpr. : s_axis_tready is low while shifting or emitting; while m_axis_tready is low the word is held,
//           TCK stays low and no command word is taken.
// Ports   : clk/rst (sync, active-high); s_axis_* command stream in; m_axis_* TDO stream out;
//           jtag_tck/tms/tdi registered pin drives; jtag_tdo pre-synchronised TDO; busy = not idle.
module xvc_jtag_shifter #(
    parameter int TCK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        jtag_tck,
    output logic        jtag_tms,
    output logic        jtag_tdi,
    input  logic        jtag_tdo,
    output logic        busy
);

    localparam int DW = $clog2(TCK_DIV + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(TCK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_TMS,
        ST_LOAD_TDI,
        ST_SHIFT,
        ST_EMIT
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic          rst_done;     // keeps the input closed during reset and for the edge that releases it
    logic [31:0]   remaining;
    logic [31:0]   tms_word;
    logic [31:0]   tdi_word;
    logic [31:0]   tdo_word;
    logic [5:0]    word_bits;
    logic [4:0]    bit_idx;
    logic [4:0]    nxt_idx;
    logic [DW-1:0] div_cnt;

    logic          in_fire;
    logic          out_fire;
    logic          phase_end;
    logic          bit_fall;
    logic          last_bit;

    // ------------------------------------------------------------------
    // Handshakes and status, all derived from registered state
    // ------------------------------------------------------------------
    assign s_axis_tready = rst_done && ((state_q == ST_IDLE) ||
                                        (state_q == ST_LOAD_TMS) ||
                                        (state_q == ST_LOAD_TDI));
    assign m_axis_tvalid = (state_q == ST_EMIT);
    assign m_axis_tlast  = (state_q == ST_EMIT) && (remaining == 32'd0);
    assign m_axis_tdata  = tdo_word;
    assign busy          = (state_q != ST_IDLE);

    assign in_fire   = s_axis_tvalid && s_axis_tready;
    assign out_fire  = m_axis_tvalid && m_axis_tready;
    assign phase_end = (div_cnt == DIV_LAST);
    // The edge that ends a TCK-high phase is the falling edge: TDO is sampled there.
    assign bit_fall  = (state_q == ST_SHIFT) && jtag_tck && phase_end;
    assign last_bit  = ({1'b0, bit_idx} == (word_bits - 6'd1));
    assign nxt_idx   = bit_idx + 5'd1;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // A zero-length header is swallowed without leaving IDLE.
                if (in_fire && (s_axis_tdata != 32'd0)) begin
                    state_d = ST_LOAD_TMS;
                end
            end
            ST_LOAD_TMS: begin
                if (in_fire) begin
                    state_d = ST_LOAD_TDI;
                end
            end
            ST_LOAD_TDI: begin
                if (in_fire) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_fall && last_bit) begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_fire) begin
                    state_d = (remaining == 32'd0) ? ST_IDLE : ST_LOAD_TMS;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and JTAG pin drive
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_done  <= 1'b0;
            remaining <= 32'd0;
            tms_word  <= 32'd0;
            tdi_word  <= 32'd0;
            tdo_word  <= 32'd0;
            word_bits <= 6'd0;
            bit_idx   <= 5'd0;
            div_cnt   <= '0;
            jtag_tck  <= 1'b0;
            jtag_tms  <= 1'b0;
            jtag_tdi  <= 1'b0;
        end else begin
            rst_done <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (in_fire) begin
                        remaining <= s_axis_tdata;
                    end
                end
                ST_LOAD_TMS: begin
                    if (in_fire) begin
                        tms_word <= s_axis_tdata;
                    end
                end
                ST_LOAD_TDI: begin
                    if (in_fire) begin
                        tdi_word  <= s_axis_tdata;
                        tdo_word  <= 32'd0;
                        word_bits <= (remaining >= 32'd32) ? 6'd32 : remaining[5:0];
                        bit_idx   <= 5'd0;
                        div_cnt   <= '0;
                        jtag_tck  <= 1'b0;
                        // Present bit 0 immediately so the first SHIFT cycle already shows it.
                        jtag_tms  <= tms_word[0];
                        jtag_tdi  <= s_axis_tdata[0];
                    end
                end
                ST_SHIFT: begin
                    if (phase_end) begin
                        div_cnt <= '0;
                        if (!jtag_tck) begin
                            jtag_tck <= 1'b1;
                        end else begin
                            jtag_tck          <= 1'b0;
                            tdo_word[bit_idx] <= jtag_tdo;
                            remaining         <= remaining - 32'd1;
                            // After the last bit TMS/TDI simply keep their value.
                            if (!last_bit) begin
                                bit_idx  <= nxt_idx;
                                jtag_tms <= tms_word[nxt_idx];
                                jtag_tdi <= tdi_word[nxt_idx];
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
